polyt1_unpack_stream: RTL

Streaming decoder for the packed t1 public-key component. It accepts the 10-bit-per-coefficient byte format produced by the t1 packer (320 bytes per polynomial) one byte per handshake and emits unpacked coefficients one per handshake, zero-extended to the 32-bit coefficient word. It sits on the public-key load path of the verify datapath, feeding the t1 polynomial RAM. It handles K consecutive polynomials per frame.

---
 rtl/dilithium_pkg.sv | 18 +
 rtl/polyt1_unpack_stream_bitbuf.sv | 40 ++++
 rtl/polyt1_unpack_stream.sv | 78 +++++++
 3 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants for the t1 pack/unpack path: ring size, coefficient width
// and packed polynomial size, plus bit-buffer sizing used by the unpacker.
package dilithium_pkg;
  localparam int N                  = 256;
  localparam int T1_BITS            = 10;
  localparam int POLYT1_PACKEDBYTES = 320;

  localparam int BBUF_W = 16;
  localparam int CNT_W  = 5;

  typedef logic [T1_BITS-1:0] t1_coef_t;
  typedef logic [CNT_W-1:0]   bbuf_cnt_t;

  // Index width for a K-entry counter; never narrower than one bit.
  function automatic int poly_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction
endpackage

// File: rtl/polyt1_unpack_stream_bitbuf.sv
// 16-bit LSB-first bit buffer: pushes whole bytes at the fill point and pops
// 10-bit coefficients from the bottom. Knows nothing about frames.
module t1_bitbuf
  import dilithium_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_byte,
  input  logic       i_pop,
  output logic       o_can_push,
  output logic       o_can_pop,
  output t1_coef_t   o_coef
);

  logic [BBUF_W-1:0] r_bbuf;
  bbuf_cnt_t         r_cnt;
  logic [BBUF_W-1:0] w_push_bits;

  // Bits at and above r_cnt are always zero, so OR-ing the byte in is enough.
  assign w_push_bits = BBUF_W'(i_byte) << r_cnt;

  assign o_can_push = (r_cnt <= CNT_W'(BBUF_W - 8));
  assign o_can_pop  = (r_cnt >= CNT_W'(T1_BITS));
  assign o_coef     = r_bbuf[T1_BITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bbuf <= '0;
      r_cnt  <= '0;
    end else if (i_pop && o_can_pop) begin
      r_bbuf <= r_bbuf >> T1_BITS;
      r_cnt  <= r_cnt - CNT_W'(T1_BITS);
    end else if (i_push && o_can_push) begin
      r_bbuf <= r_bbuf | w_push_bits;
      r_cnt  <= r_cnt + CNT_W'(8);
    end
  end

endmodule

// File: rtl/polyt1_unpack_stream.sv
// Streaming t1 unpacker: one packed byte in, one zero-extended 10-bit
// coefficient out per handshake, K polynomials of 256 coefficients per frame.
module polyt1_unpack_stream
  import dilithium_pkg::*;
#(
  parameter int K  = 4,
  parameter int CW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [poly_w(K)-1:0]  out_poly,
  output logic                  done
);

  localparam int             PW        = poly_w(K);
  localparam logic [PW-1:0]  LAST_POLY = PW'(K - 1);
  localparam logic [7:0]     LAST_CIDX = 8'(N - 1);

  logic     w_can_push;
  logic     w_can_pop;
  logic     w_pop;
  t1_coef_t w_coef;

  logic [7:0]    r_cidx;
  logic [PW-1:0] r_poly;
  logic          r_done;

  t1_bitbuf u_bitbuf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (in_valid),
    .i_byte     (in_data),
    .i_pop      (out_ready),
    .o_can_push (w_can_push),
    .o_can_pop  (w_can_pop),
    .o_coef     (w_coef)
  );

  assign w_pop = w_can_pop && out_ready;

  // 320 bytes carry exactly 256 coefficients, so the buffer is empty at every
  // polynomial boundary and only the counters need to track frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cidx <= '0;
      r_poly <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_cidx <= r_cidx + 8'd1;
        if (r_cidx == LAST_CIDX) begin
          if (r_poly == LAST_POLY) begin
            r_poly <= '0;
            r_done <= 1'b1;
          end else begin
            r_poly <= r_poly + PW'(1);
          end
        end
      end
    end
  end

  assign in_ready  = w_can_push;
  assign out_valid = w_can_pop;
  assign out_data  = CW'(w_coef);
  assign out_last  = w_can_pop && (r_cidx == LAST_CIDX);
  assign out_poly  = r_poly;
  assign done      = r_done;

endmodule
